// File: rtl/dc_neighbour_fetch.sv
// rtl/dc_neighbour_fetch.sv - raster-order 4x4 block walker feeding left/above neighbours to the intra predictor
module dc_neighbour_fetch #(
    parameter int FRAME_W_BLKS = 16,
    parameter int FRAME_H_BLKS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    output logic        nb_valid,
    input  logic        nb_ready,
    output logic        haveLeft,
    output logic        haveAbove,
    output logic [29:0] leftCol  [0:7],
    output logic [29:0] aboveRow [0:7],
    output logic [7:0]  blk_x,
    output logic [7:0]  blk_y,
    input  logic        recon_valid,
    output logic        recon_ready,
    input  logic [29:0] recon_blk [0:3][0:3],
    output logic        frame_done
);

    localparam int AW = (FRAME_W_BLKS > 1) ? $clog2(FRAME_W_BLKS) : 1;
    localparam logic [7:0] X_LAST = 8'(FRAME_W_BLKS - 1);
    localparam logic [7:0] Y_LAST = 8'(FRAME_H_BLKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_SERVE, S_WAIT_RECON, S_UPDATE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic        have_left_q, have_left_d, have_above_q, have_above_d;
    logic [29:0] left_q  [0:7];
    logic [29:0] left_d  [0:7];
    logic [29:0] above_q [0:7];
    logic [29:0] above_d [0:7];
    logic [29:0] row3_q  [0:3];
    logic [29:0] col3_q  [0:3];
    logic [29:0] linebuf_q [0:(1<<AW)-1][0:3];
    logic        cap_en, wr_en, last_blk, right_ok;
    logic [8:0]  nx1;

    // Line buffer read that forwards the row being written this cycle.
    function automatic logic [29:0] lb_rd(input logic [8:0] idx, input logic [1:0] c);
        if (idx == {1'b0, x_q}) return row3_q[c];
        return linebuf_q[idx[AW-1:0]][c];
    endfunction

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        have_left_d  = have_left_q;
        have_above_d = have_above_q;
        left_d       = left_q;
        above_d      = above_q;
        cap_en       = 1'b0;
        wr_en        = 1'b0;
        last_blk     = (x_q == X_LAST) && (y_q == Y_LAST);
        nx1          = '0;
        right_ok     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d      = S_SERVE;
                    x_d          = '0;
                    y_d          = '0;
                    have_left_d  = 1'b0;
                    have_above_d = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        left_d[i]  = '0;
                        above_d[i] = '0;
                    end
                end
            end
            S_SERVE: begin
                if (nb_ready) state_d = S_WAIT_RECON;
            end
            S_WAIT_RECON: begin
                if (recon_valid) begin
                    cap_en  = 1'b1;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                wr_en = 1'b1;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = last_blk ? 8'd0 : y_q + 8'd1;
                end else begin
                    x_d = x_q + 8'd1;
                end
                have_left_d  = (x_d != 8'd0);
                have_above_d = (y_d != 8'd0);
                nx1          = {1'b0, x_d} + 9'd1;
                right_ok     = have_above_d && (nx1 < 9'(FRAME_W_BLKS));
                for (int i = 0; i < 4; i++) begin
                    left_d[i]     = have_left_d ? col3_q[i] : '0;
                    left_d[4+i]   = have_left_d ? col3_q[3] : '0;
                    above_d[i]    = have_above_d ? lb_rd({1'b0, x_d}, 2'(i)) : '0;
                    above_d[4+i]  = right_ok ? lb_rd(nx1, 2'(i))
                                  : (have_above_d ? lb_rd({1'b0, x_d}, 2'd3) : '0);
                end
                state_d = last_blk ? S_DONE : S_SERVE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            have_left_q  <= 1'b0;
            have_above_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                left_q[i]  <= '0;
                above_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            have_left_q  <= have_left_d;
            have_above_q <= have_above_d;
            for (int i = 0; i < 8; i++) begin
                left_q[i]  <= left_d[i];
                above_q[i] <= above_d[i];
            end
        end
    end

    // Only the bottom row and right column of a block are ever reused.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int i = 0; i < 4; i++) begin
                row3_q[i] <= recon_blk[3][i];
                col3_q[i] <= recon_blk[i][3];
            end
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) linebuf_q[x_q[AW-1:0]][i] <= row3_q[i];
        end
    end

    assign nb_valid    = (state_q == S_SERVE);
    assign recon_ready = (state_q == S_WAIT_RECON);
    assign frame_done  = (state_q == S_DONE);
    assign haveLeft    = have_left_q;
    assign haveAbove   = have_above_q;
    assign leftCol     = left_q;
    assign aboveRow    = above_q;
    assign blk_x       = x_q;
    assign blk_y       = y_q;

endmodule

// File: tb/tb_dc_neighbour_fetch.sv
// tb/tb_dc_neighbour_fetch.sv - randomized model-checked bench for dc_neighbour_fetch over three frame shapes
module tb_dc_neighbour_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] pix(input int k);
        return {10'(k), 10'(k), 10'(k)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 5;
        localparam int H = (g == 0) ? 2 : (g == 1) ? 3 : 4;
        localparam int N = W * H;

        logic        rst_n, frame_start, nb_valid, nb_ready, haveLeft, haveAbove;
        logic        recon_valid, recon_ready, frame_done;
        logic [29:0] leftCol  [0:7];
        logic [29:0] aboveRow [0:7];
        logic [29:0] recon_blk [0:3][0:3];
        logic [7:0]  blk_x, blk_y;
        logic [29:0] img [0:N-1][0:3][0:3];
        int          blk_n = 0;
        int          mode  = 0;
        bit          fin   = 1'b0;

        dc_neighbour_fetch #(.FRAME_W_BLKS(W), .FRAME_H_BLKS(H)) dut (
            .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
            .nb_valid(nb_valid), .nb_ready(nb_ready),
            .haveLeft(haveLeft), .haveAbove(haveAbove),
            .leftCol(leftCol), .aboveRow(aboveRow),
            .blk_x(blk_x), .blk_y(blk_y),
            .recon_valid(recon_valid), .recon_ready(recon_ready),
            .recon_blk(recon_blk), .frame_done(frame_done)
        );

        // Expected neighbours straight from the reconstructed frame image.
        function automatic logic [29:0] exp_left(input int n, input int i);
            int j = (i > 3) ? 3 : i;
            if (n % W == 0) return 30'd0;
            return img[n-1][j][3];
        endfunction

        function automatic logic [29:0] exp_above(input int n, input int i);
            int x = n % W;
            if (n / W == 0) return 30'd0;
            if (i < 4) return img[n-W][3][i];
            if (x + 1 < W) return img[n-W+1][3][i-4];
            return img[n-W][3][3];
        endfunction

        task automatic fill(input int m);
            for (int n = 0; n < N; n++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        if (m == 0) img[n][r][c] = pix(n + 1);
                        else if (m == 2 && n == 0)
                            img[n][r][c] = {10'($urandom), 10'($urandom), 10'(4 * r + c)};
                        else img[n][r][c] = 30'($urandom);
                    end
        endtask

        task automatic drive_recon();
            int k = (blk_n < N) ? blk_n : N - 1;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) recon_blk[r][c] = img[k][r][c];
        endtask

        task automatic run_frame(input int m, input bit full);
            int c;
            mode = m;
            fill(m);
            frame_start = 1'b1;
            drive_recon();
            @(posedge clk); #1;
            frame_start = 1'b0;
            c = 1;
            while (1) begin
                nb_ready    = full || (c > 5 && $urandom_range(0, 3) != 0);
                recon_valid = full || ($urandom_range(0, 2) != 0);
                drive_recon();
                @(posedge clk); #1;
                c++;
                if (frame_done) break;
                if (c > 4000) begin
                    total++; bad++;
                    $display("FAIL cfg%0d frame timeout: got no frame_done after %0d cycles", g, c);
                    break;
                end
            end
            if (full) chk($sformatf("cfg%0d cycles to frame_done", g), c, 3 * N + 1);
            nb_ready = 1'b0;
            recon_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("cfg%0d frame_done single pulse", g), frame_done, 0);
            chk($sformatf("cfg%0d idle after done", g), nb_valid, 0);
        endtask

        task automatic check_all_zero(input string tag);
            chk($sformatf("cfg%0d %s nb_valid", g, tag), nb_valid, 0);
            chk($sformatf("cfg%0d %s recon_ready", g, tag), recon_ready, 0);
            chk($sformatf("cfg%0d %s frame_done", g, tag), frame_done, 0);
            chk($sformatf("cfg%0d %s haves", g, tag), {haveLeft, haveAbove}, 0);
            chk($sformatf("cfg%0d %s pos", g, tag), {blk_y, blk_x}, 0);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("cfg%0d %s leftCol[%0d]", g, tag, i), leftCol[i], 0);
                chk($sformatf("cfg%0d %s aboveRow[%0d]", g, tag, i), aboveRow[i], 0);
            end
        endtask

        task automatic reset_mid();
            int c = 0;
            mode = 1;
            fill(1);
            frame_start = 1'b1;
            nb_ready    = 1'b1;
            recon_valid = 1'b1;
            drive_recon();
            @(posedge clk); #1;
            frame_start = 1'b0;
            while (!(blk_n == 1 && recon_ready) && c < 50) begin
                recon_valid = (blk_n == 0);
                drive_recon();
                @(posedge clk); #1;
                c++;
            end
            chk($sformatf("cfg%0d waiting on second block", g), {recon_ready, 8'(blk_n)}, {1'b1, 8'd1});
            rst_n = 1'b0;
            #1;
            check_all_zero("mid-frame reset");
            @(posedge clk); #1;
            rst_n = 1'b1;
            recon_valid = 1'b0;
            nb_ready = 1'b0;
            @(posedge clk); #1;
        endtask

        initial begin : drv
            rst_n = 1'b0;
            frame_start = 1'b0;
            nb_ready = 1'b0;
            recon_valid = 1'b0;
            fill(0);
            drive_recon();
            repeat (3) @(posedge clk);
            #1;
            check_all_zero("reset");
            rst_n = 1'b1;
            @(posedge clk); #1;
            run_frame(0, 1'b1);
            run_frame(2, 1'b0);
            run_frame(1, 1'b0);
            run_frame(0, 1'b0);
            reset_mid();
            run_frame(1, 1'b1);
            run_frame(2, 1'b0);
            fin = 1'b1;
        end

        initial begin : mon
            bit rr_prev = 1'b0;
            bit rv_prev = 1'b0;
            int ex, ey;
            forever begin
                @(negedge clk);
                if (!rst_n || frame_start) blk_n = 0;
                if (rst_n && nb_valid) begin
                    ex = blk_n % W;
                    ey = blk_n / W;
                    chk($sformatf("cfg%0d blk%0d pos", g, blk_n), {blk_y, blk_x}, 32'(ey * 256 + ex));
                    chk($sformatf("cfg%0d blk%0d haveLeft", g, blk_n), haveLeft, 32'(ex != 0));
                    chk($sformatf("cfg%0d blk%0d haveAbove", g, blk_n), haveAbove, 32'(ey != 0));
                    for (int i = 0; i < 8; i++) begin
                        chk($sformatf("cfg%0d blk%0d leftCol[%0d]", g, blk_n, i), leftCol[i], exp_left(blk_n, i));
                        chk($sformatf("cfg%0d blk%0d aboveRow[%0d]", g, blk_n, i), aboveRow[i], exp_above(blk_n, i));
                    end
                    if (mode == 0 && ex == 1 && ey == 0)
                        chk($sformatf("cfg%0d literal leftCol[7]", g), leftCol[7], pix(1));
                    if (mode == 0 && ex == 0 && ey == 1)
                        chk($sformatf("cfg%0d literal aboveRow[0]", g), aboveRow[0], pix(1));
                    if (mode == 0 && ex == W - 1 && ey == 1)
                        chk($sformatf("cfg%0d literal right edge aboveRow[7]", g), aboveRow[7], pix(W));
                    if (mode == 2 && ex == 1 && ey == 0)
                        for (int j = 0; j < 4; j++)
                            chk($sformatf("cfg%0d literal leftCol[%0d].Y", g, j), leftCol[j][9:0], 4 * j + 3);
                    if (mode == 2 && ex == 0 && ey == 1)
                        for (int j = 0; j < 4; j++)
                            chk($sformatf("cfg%0d literal aboveRow[%0d].Y", g, j), aboveRow[j][9:0], 12 + j);
                end
                if (rst_n) chk($sformatf("cfg%0d serve/wait exclusive", g), nb_valid & recon_ready, 0);
                if (rst_n && rr_prev && !rv_prev)
                    chk($sformatf("cfg%0d recon_ready held", g), recon_ready, 1);
                if (rst_n && frame_done)
                    chk($sformatf("cfg%0d frame_done after last block", g), blk_n, N);
                if (rst_n && recon_valid && recon_ready) blk_n++;
                rr_prev = rst_n && recon_ready;
                rv_prev = recon_valid;
            end
        end
    end

    initial begin : main
        int c = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && c < 60000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 60000) begin
            total++; bad++;
            $display("FAIL overall timeout: got %0d cycles without completion, required fewer than 60000", c);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
